// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine payment controller:
// drink codes and prices, coin codes and values, and the controller state encoding.
package vend_pkg;

   localparam logic [7:0] DRINK_A = 8'h21;
   localparam logic [7:0] DRINK_B = 8'h1B;
   localparam logic [7:0] DRINK_C = 8'h2B;
   localparam logic [7:0] DRINK_D = 8'h4D;

   localparam logic [7:0] PRICE_A = 8'd15;
   localparam logic [7:0] PRICE_B = 8'd20;
   localparam logic [7:0] PRICE_C = 8'd25;
   localparam logic [7:0] PRICE_D = 8'd30;

   localparam logic [1:0] COIN_1  = 2'd0;
   localparam logic [1:0] COIN_5  = 2'd1;
   localparam logic [1:0] COIN_10 = 2'd2;
   localparam logic [1:0] COIN_50 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_CHANGE  = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] value;
      case (code)
         COIN_1:  value = 8'd1;
         COIN_5:  value = 8'd5;
         COIN_10: value = 8'd10;
         default: value = 8'd50;
      endcase
      return value;
   endfunction

   // A price of zero marks an unknown drink code.
   function automatic logic [7:0] drink_price(input logic [7:0] code);
      logic [7:0] price;
      case (code)
         DRINK_A: price = PRICE_A;
         DRINK_B: price = PRICE_B;
         DRINK_C: price = PRICE_C;
         DRINK_D: price = PRICE_D;
         default: price = 8'd0;
      endcase
      return price;
   endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Greedy change selector: presents the largest coin not exceeding the
// remaining change (50, 10, 5, then 1).
module vend_change_pick
   import vend_pkg::*;
(
   input  logic [7:0] i_remaining,
   output logic [1:0] o_coin
);

   always_comb begin
      o_coin = COIN_1;
      if (i_remaining >= 8'd50)
         o_coin = COIN_50;
      else if (i_remaining >= 8'd10)
         o_coin = COIN_10;
      else if (i_remaining >= 8'd5)
         o_coin = COIN_5;
   end

endmodule

// File: rtl/vend_pay_ctrl.sv
// Payment and change controller for the drink vending machine.
// Optional refund input enabled by defining VEND_CANCEL_EN.
module vend_pay_ctrl
   import vend_pkg::*;
#(
   parameter logic [7:0] MAX_CREDIT = 8'd99
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] drink,
   input  logic       coin_valid,
   input  logic [1:0] coin_val,
`ifdef VEND_CANCEL_EN
   input  logic       cancel,
`endif
   input  logic       change_ready,
   output logic [1:0] state,
   output logic [7:0] credit,
   output logic       paid,
   output logic       coin_reject,
   output logic       change_valid,
   output logic [1:0] change_coin,
   output logic       done
);

   state_t     r_state;
   logic [7:0] r_credit;
   logic [7:0] r_price;
   logic       r_paid;
   logic       r_reject;
   logic       r_done;

   logic       w_cancel;
   logic [7:0] w_sum;
   logic [7:0] w_drinkPrice;
   logic [1:0] w_pickCoin;
   logic [7:0] w_pickValue;

`ifdef VEND_CANCEL_EN
   assign w_cancel = cancel;
`else
   assign w_cancel = 1'b0;
`endif

   assign w_sum        = r_credit + coin_value(coin_val);
   assign w_drinkPrice = drink_price(drink);
   assign w_pickValue  = coin_value(w_pickCoin);

   vend_change_pick u_pick (
      .i_remaining (r_credit),
      .o_coin      (w_pickCoin)
   );

   // In CHANGE, r_credit holds the change still owed rather than the credit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_credit <= 8'd0;
         r_price  <= 8'd0;
         r_paid   <= 1'b0;
         r_reject <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_paid   <= 1'b0;
         r_reject <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (coin_valid)
                  r_reject <= 1'b1;
               if (w_drinkPrice != 8'd0) begin
                  r_price  <= w_drinkPrice;
                  r_credit <= 8'd0;
                  r_state  <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (w_cancel) begin
                  if (coin_valid)
                     r_reject <= 1'b1;
                  if (r_credit != 8'd0) begin
                     r_state <= ST_CHANGE;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else if (coin_valid) begin
                  if (w_sum > MAX_CREDIT) begin
                     r_reject <= 1'b1;
                  end else if (w_sum >= r_price) begin
                     r_paid <= 1'b1;
                     if (w_sum == r_price) begin
                        r_credit <= w_sum;
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                     end else begin
                        r_credit <= w_sum - r_price;
                        r_state  <= ST_CHANGE;
                     end
                  end else begin
                     r_credit <= w_sum;
                  end
               end
            end
            ST_CHANGE: begin
               if (coin_valid)
                  r_reject <= 1'b1;
               if (change_ready) begin
                  r_credit <= r_credit - w_pickValue;
                  if (r_credit == w_pickValue) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               if (coin_valid)
                  r_reject <= 1'b1;
               r_credit <= 8'd0;
               r_price  <= 8'd0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign state        = r_state;
   assign credit       = r_credit;
   assign paid         = r_paid;
   assign coin_reject  = r_reject;
   assign done         = r_done;
   assign change_valid = (r_state == ST_CHANGE);
   assign change_coin  = change_valid ? w_pickCoin : 2'd0;

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// Scoreboard bench for vend_pay_ctrl: two instances (default MAX_CREDIT and 60),
// expected outputs queued with each stimulus cycle and compared after the edge.
module tb_vend_pay_ctrl;

   logic       clk = 1'b0;
   logic       resetA;
   logic       resetB;
   logic [7:0] drink;
   logic       coinValid;
   logic [1:0] coinVal;
   logic       changeReady;
`ifdef VEND_CANCEL_EN
   logic       cancel;
`endif

   logic [1:0] stateA, ccoinA, stateB, ccoinB;
   logic [7:0] creditA, creditB;
   logic       paidA, rejectA, cvalidA, doneA;
   logic       paidB, rejectB, cvalidB, doneB;

   typedef struct packed {
      logic       sel;
      logic [1:0] st;
      logic [7:0] cr;
      logic       pd;
      logic       rj;
      logic       cv;
      logic [1:0] cc;
      logic       dn;
   } exp_t;

   exp_t  expQ[$];
   string tagQ[$];
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   vend_pay_ctrl dutA (
      .clk          (clk),
      .reset        (resetA),
      .drink        (drink),
      .coin_valid   (coinValid),
      .coin_val     (coinVal),
`ifdef VEND_CANCEL_EN
      .cancel       (cancel),
`endif
      .change_ready (changeReady),
      .state        (stateA),
      .credit       (creditA),
      .paid         (paidA),
      .coin_reject  (rejectA),
      .change_valid (cvalidA),
      .change_coin  (ccoinA),
      .done         (doneA)
   );

   vend_pay_ctrl #(.MAX_CREDIT(8'd60)) dutB (
      .clk          (clk),
      .reset        (resetB),
      .drink        (drink),
      .coin_valid   (coinValid),
      .coin_val     (coinVal),
`ifdef VEND_CANCEL_EN
      .cancel       (cancel),
`endif
      .change_ready (changeReady),
      .state        (stateB),
      .credit       (creditB),
      .paid         (paidB),
      .coin_reject  (rejectB),
      .change_valid (cvalidB),
      .change_coin  (ccoinB),
      .done         (doneB)
   );

   task automatic checkOutput(input string tag, input int obs, input int expv);
      total++;
      if (obs != expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic sel, input logic [1:0] st, input int cr,
                               input logic pd, input logic rj, input logic cv,
                               input logic [1:0] cc, input logic dn);
      exp_t e;
      e.sel = sel;
      e.st  = st;
      e.cr  = 8'(cr);
      e.pd  = pd;
      e.rj  = rj;
      e.cv  = cv;
      e.cc  = cc;
      e.dn  = dn;
      return e;
   endfunction

   task automatic compareFront();
      exp_t  e;
      exp_t  o;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (!e.sel)
         o = {1'b0, stateA, creditA, paidA, rejectA, cvalidA, ccoinA, doneA};
      else
         o = {1'b1, stateB, creditB, paidB, rejectB, cvalidB, ccoinB, doneB};
      checkOutput({t, ".state"},  int'(o.st), int'(e.st));
      checkOutput({t, ".credit"}, int'(o.cr), int'(e.cr));
      checkOutput({t, ".paid"},   int'(o.pd), int'(e.pd));
      checkOutput({t, ".reject"}, int'(o.rj), int'(e.rj));
      checkOutput({t, ".cvalid"}, int'(o.cv), int'(e.cv));
      checkOutput({t, ".ccoin"},  int'(o.cc), int'(e.cc));
      checkOutput({t, ".done"},   int'(o.dn), int'(e.dn));
   endtask

   task automatic applyStimulus(input string tag, input logic [7:0] d, input logic cv,
                                input logic [1:0] cval, input logic rdy, input exp_t e);
      @(negedge clk);
      drink       = d;
      coinValid   = cv;
      coinVal     = cval;
      changeReady = rdy;
      expQ.push_back(e);
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
      compareFront();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetA      = 1'b0;
      resetB      = 1'b0;
      drink       = 8'h00;
      coinValid   = 1'b0;
      coinVal     = 2'd0;
      changeReady = 1'b0;
`ifdef VEND_CANCEL_EN
      cancel      = 1'b0;
`endif
      #2;
      checkOutput("rst.state",  int'(stateA),  0);
      checkOutput("rst.credit", int'(creditA), 0);
      checkOutput("rst.cvalid", int'(cvalidA), 0);
      #10;
      resetA = 1'b1;

      applyStimulus("idle", 8'h00, 0, 2'd0, 0, mk(0, 2'b00, 0, 0, 0, 0, 0, 0));

      // Exact payment: 0x21 costs 15, paid by 10 then 5.
      applyStimulus("t1.sel",  8'h21, 0, 2'd0, 0, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t1.c10",  8'h00, 1, 2'd2, 0, mk(0, 2'b01, 10, 0, 0, 0, 0, 0));
      applyStimulus("t1.c5",   8'h00, 1, 2'd1, 0, mk(0, 2'b11, 15, 1, 0, 0, 0, 1));
      applyStimulus("t1.end",  8'h00, 0, 2'd0, 0, mk(0, 2'b00, 0,  0, 0, 0, 0, 0));

      // 0x4D costs 30, a 50 coin leaves 20 returned as two 10s.
      applyStimulus("t2.sel",  8'h4D, 0, 2'd0, 1, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t2.c50",  8'h00, 1, 2'd3, 1, mk(0, 2'b10, 20, 1, 0, 1, 2, 0));
      applyStimulus("t2.ch1",  8'h00, 0, 2'd0, 1, mk(0, 2'b10, 10, 0, 0, 1, 2, 0));
      applyStimulus("t2.ch2",  8'h00, 0, 2'd0, 1, mk(0, 2'b11, 0,  0, 0, 0, 0, 1));
      applyStimulus("t2.end",  8'h00, 0, 2'd0, 1, mk(0, 2'b00, 0,  0, 0, 0, 0, 0));

      // 0x1B costs 20, 25 inserted, the single 5 change coin waits for ready.
      applyStimulus("t3.sel",  8'h1B, 0, 2'd0, 0, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t3.c10",  8'h00, 1, 2'd2, 0, mk(0, 2'b01, 10, 0, 0, 0, 0, 0));
      applyStimulus("t3.c5",   8'h00, 1, 2'd1, 0, mk(0, 2'b01, 15, 0, 0, 0, 0, 0));
      applyStimulus("t3.c10b", 8'h00, 1, 2'd2, 0, mk(0, 2'b10, 5,  1, 0, 1, 1, 0));
      for (int i = 0; i < 3; i++)
         applyStimulus("t3.hold", 8'h00, 0, 2'd0, 0, mk(0, 2'b10, 5, 0, 0, 1, 1, 0));
      applyStimulus("t3.acc",  8'h00, 0, 2'd0, 1, mk(0, 2'b11, 0,  0, 0, 0, 0, 1));
      applyStimulus("t3.end",  8'h00, 0, 2'd0, 0, mk(0, 2'b00, 0,  0, 0, 0, 0, 0));

      // Invalid drink code stays idle and coins are refused.
      applyStimulus("t4.sel",  8'h99, 0, 2'd0, 0, mk(0, 2'b00, 0, 0, 0, 0, 0, 0));
      applyStimulus("t4.coin", 8'h99, 1, 2'd2, 0, mk(0, 2'b00, 0, 0, 1, 0, 0, 0));
      applyStimulus("t4.end",  8'h00, 0, 2'd0, 0, mk(0, 2'b00, 0, 0, 0, 0, 0, 0));

      // 0x2B costs 25, 70 inserted, 45 change as 10,10,10,10,5.
      applyStimulus("t5.sel",  8'h2B, 0, 2'd0, 1, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t5.c10",  8'h00, 1, 2'd2, 1, mk(0, 2'b01, 10, 0, 0, 0, 0, 0));
      applyStimulus("t5.c10b", 8'h00, 1, 2'd2, 1, mk(0, 2'b01, 20, 0, 0, 0, 0, 0));
      applyStimulus("t5.c50",  8'h00, 1, 2'd3, 1, mk(0, 2'b10, 45, 1, 0, 1, 2, 0));
      applyStimulus("t5.ch1",  8'h00, 0, 2'd0, 1, mk(0, 2'b10, 35, 0, 0, 1, 2, 0));
      applyStimulus("t5.ch2",  8'h00, 0, 2'd0, 1, mk(0, 2'b10, 25, 0, 0, 1, 2, 0));
      applyStimulus("t5.ch3",  8'h00, 0, 2'd0, 1, mk(0, 2'b10, 15, 0, 0, 1, 2, 0));
      applyStimulus("t5.ch4",  8'h00, 1, 2'd0, 1, mk(0, 2'b10, 5,  0, 1, 1, 1, 0));
      applyStimulus("t5.ch5",  8'h00, 0, 2'd0, 1, mk(0, 2'b11, 0,  0, 0, 0, 0, 1));
      applyStimulus("t5.end",  8'h00, 0, 2'd0, 1, mk(0, 2'b00, 0,  0, 0, 0, 0, 0));

      // Same purchase on the MAX_CREDIT=60 instance: the 50 coin overflows.
      resetA = 1'b0;
      resetB = 1'b1;
      applyStimulus("t6.sel",  8'h2B, 0, 2'd0, 1, mk(1, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t6.c10",  8'h00, 1, 2'd2, 1, mk(1, 2'b01, 10, 0, 0, 0, 0, 0));
      applyStimulus("t6.c10b", 8'h00, 1, 2'd2, 1, mk(1, 2'b01, 20, 0, 0, 0, 0, 0));
      applyStimulus("t6.c50",  8'h00, 1, 2'd3, 1, mk(1, 2'b01, 20, 0, 1, 0, 0, 0));
      applyStimulus("t6.c5",   8'h00, 1, 2'd1, 1, mk(1, 2'b11, 25, 1, 0, 0, 0, 1));
      applyStimulus("t6.end",  8'h00, 0, 2'd0, 1, mk(1, 2'b00, 0,  0, 0, 0, 0, 0));
      resetB = 1'b0;
      resetA = 1'b1;

`ifdef VEND_CANCEL_EN
      // Cancel with a coin in the same cycle: coin refused, 10 refunded, never paid.
      applyStimulus("t7.sel",  8'h2B, 0, 2'd0, 1, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t7.c10",  8'h00, 1, 2'd2, 1, mk(0, 2'b01, 10, 0, 0, 0, 0, 0));
      cancel = 1'b1;
      applyStimulus("t7.can",  8'h00, 1, 2'd3, 1, mk(0, 2'b10, 10, 0, 1, 1, 2, 0));
      cancel = 1'b0;
      applyStimulus("t7.ref",  8'h00, 0, 2'd0, 1, mk(0, 2'b11, 0,  0, 0, 0, 0, 1));
      applyStimulus("t7.end",  8'h00, 0, 2'd0, 1, mk(0, 2'b00, 0,  0, 0, 0, 0, 0));
`endif

      // Reset in the middle of paying change clears everything at once.
      applyStimulus("t8.sel",  8'h4D, 0, 2'd0, 0, mk(0, 2'b01, 0,  0, 0, 0, 0, 0));
      applyStimulus("t8.c50",  8'h00, 1, 2'd3, 0, mk(0, 2'b10, 20, 1, 0, 1, 2, 0));
      #2;
      resetA = 1'b0;
      #1;
      checkOutput("t8.rst.state",  int'(stateA),  0);
      checkOutput("t8.rst.credit", int'(creditA), 0);
      checkOutput("t8.rst.paid",   int'(paidA),   0);
      checkOutput("t8.rst.cvalid", int'(cvalidA), 0);
      checkOutput("t8.rst.ccoin",  int'(ccoinA),  0);
      #1;
      resetA = 1'b1;
      applyStimulus("t8.end",  8'h00, 0, 2'd0, 1, mk(0, 2'b00, 0, 0, 0, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
